// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared ALU control codes and divider FSM state encodings for the HI/LO unit
package hilo_muldiv_pkg;
  typedef logic [4:0] ctrl_t;
  localparam ctrl_t DIV_CONTROL   = 5'b01010;
  localparam ctrl_t DIVU_CONTROL  = 5'b01011;
  localparam ctrl_t MULT_CONTROL  = 5'b01100;
  localparam ctrl_t MULTU_CONTROL = 5'b01101;
  localparam ctrl_t MTHI_CONTROL  = 5'b01110;
  localparam ctrl_t MTLO_CONTROL  = 5'b01111;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic logic is_div(input ctrl_t c);
    return c == DIV_CONTROL || c == DIVU_CONTROL;
  endfunction
  function automatic logic is_mul(input ctrl_t c);
    return c == MULT_CONTROL || c == MULTU_CONTROL;
  endfunction
endpackage

// File: rtl/hilo_muldiv_unit_div.sv
// div_radix2: iterative unsigned restoring divider, one quotient bit per cycle, MSB first
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0] cnt;
  logic run;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0] trial, diff;
  // quotient register doubles as the dividend shifter; borrow out means the trial subtract fails
  assign trial = {remainder, quotient[WIDTH-1]};
  assign diff = trial - {1'b0, dvs};
  assign done = run & (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      dvs <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      quotient <= dividend;
      remainder <= '0;
      dvs <= divisor;
    end else if (abort) begin
      run <= 1'b0;
    end else if (run) begin
      remainder <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      quotient <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt + 1'b1;
      run <= ~done;
    end
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register pair with single-cycle MULT/MULTU, MTHI/MTLO and iterative DIV/DIVU
// Optional DIV_ZERO_FAST_EN: zero divisor skips the iterations and writes HI=dividend, LO=all-ones
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alucontrol_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  state_t state, state_n;
  logic acc, start, dz, sgn, a_neg, b_neg, q_neg, r_neg, core_done;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem, q_fix, r_fix, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;
  assign acc = valid_i & ~flush_i;
  assign start = acc & (state == IDLE) & is_div(alucontrol_i);
  assign sgn = alucontrol_i == DIV_CONTROL;
  assign a_neg = sgn & srca_i[WIDTH-1];
  assign b_neg = sgn & srcb_i[WIDTH-1];
  assign a_mag = a_neg ? -srca_i : srca_i;
  assign b_mag = b_neg ? -srcb_i : srcb_i;
  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem : rem;
  // sign-extending to full width makes the low 2*WIDTH bits of an unsigned multiply the signed product
  assign prod = alucontrol_i == MULT_CONTROL
    ? {{WIDTH{srca_i[WIDTH-1]}}, srca_i} * {{WIDTH{srcb_i[WIDTH-1]}}, srcb_i}
    : {{WIDTH{1'b0}}, srca_i} * {{WIDTH{1'b0}}, srcb_i};
`ifdef DIV_ZERO_FAST_EN
  logic zero_q;
  logic [WIDTH-1:0] zero_hi;
  assign dz = srcb_i == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      zero_hi <= '0;
    end else if (start) begin
      zero_q <= dz;
      zero_hi <= srca_i;
    end
  end
  assign fin_hi = zero_q ? zero_hi : r_fix;
  assign fin_lo = zero_q ? '1 : q_fix;
`else
  assign dz = 1'b0;
  assign fin_hi = r_fix;
  assign fin_lo = q_fix;
`endif
  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start & ~dz),
    .abort     (flush_i & (state != IDLE)),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .done      (core_done)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (start ? (dz ? DONE : BUSY) : IDLE)
            : state == BUSY ? (flush_i ? IDLE : (core_done ? DONE : BUSY))
            : IDLE;
  end
  always_comb begin
    stall_o = ~rst & (start | ((state == BUSY) & ~flush_i));
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      if (start) begin
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
      end
      if (state == DONE && !flush_i) begin
        hi_o <= fin_hi;
        lo_o <= fin_lo;
      end else if (acc && state == IDLE) begin
        hi_o <= alucontrol_i == MTHI_CONTROL ? srca_i : (is_mul(alucontrol_i) ? prod[2*WIDTH-1:WIDTH] : hi_o);
        lo_o <= alucontrol_i == MTLO_CONTROL ? srca_i : (is_mul(alucontrol_i) ? prod[WIDTH-1:0] : lo_o);
      end
    end
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Execution-side consumer of the 5-bit ALU control codes for the HI/LO class of instructions: DIV, DIVU, MULT, MULTU, MTHI and MTLO.
- Owns the architectural HI/LO register pair.
- Runs a multi-cycle radix-2 restoring divider and holds the pipeline stall while it runs.
- Sits in EX beside the ALU. MFHI/MFLO read hi_o/lo_o directly.

Parameters:
- WIDTH, 32, operand, HI and LO width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- alucontrol_i  input  5  ALU control code of the EX-stage instruction (shared control-code defines)
- valid_i  input  1  EX-stage instruction is valid
- flush_i  input  1  EX-stage flush (exception/branch kill)
- srca_i  input  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data)
- srcb_i  input  WIDTH  rt operand (divisor, multiplier)
- stall_o  output  1  request to freeze IF..EX
- busy_o  output  1  divider FSM not IDLE
- hi_o  output  WIDTH  current HI register
- lo_o  output  WIDTH  current LO register

Behaviour:
- Reset (rst=1 at a clock edge): HI=0, LO=0, FSM=IDLE, iteration counter=0. stall_o=0 and busy_o=0 from the next cycle. Reset aborts any divide in progress with no HI/LO write.
- Accept condition: acc = valid_i & ~flush_i. Operation codes other than the six listed are ignored.
- MTHI: on acc, HI <= srca_i at the edge.
- MTLO: on acc, LO <= srca_i at the edge.
- MULT/MULTU: on acc, {HI,LO} <= full 2*WIDTH product at the edge.
  - MULT: signed × signed. MULTU: unsigned × unsigned.
  - Single cycle; stall_o stays 0.
- DIV/DIVU FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY, in cycle T with acc and a DIV/DIVU code:
  - stall_o=1 combinationally in cycle T.
  - Latch magnitudes (DIV) or raw values (DIVU) of both operands, plus quotient and remainder sign flags.
  - Counter <= 0.
- BUSY: one quotient bit per cycle, MSB first. Counter increments each cycle.
  - After WIDTH iterations (cycles T+1..T+WIDTH), go to DONE.
  - stall_o=1 throughout BUSY.
- DONE, cycle T+WIDTH+1:
  - Sign correction: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - HI <= remainder and LO <= quotient at the edge.
  - stall_o=0 and busy_o=1.
  - Next state is always IDLE. A still-present valid DIV code in DONE is the same instruction and is not re-accepted.
- Stall length: 33 consecutive cycles at WIDTH=32 (T..T+32).
- flush_i during BUSY or DONE: FSM goes to IDLE at that edge, no HI/LO write, stall_o=0 in the flush cycle.
- While busy_o=1, all other codes are ignored; the pipeline is frozen, so none arrive.
- Divide by zero result: unpredictable unless the optional feature below is compiled in. Latency is always as specified.
- hi_o/lo_o are the register outputs. A write becomes visible the cycle after its edge; there is no internal bypass.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: DIV/DIVU with srcb_i==0 goes IDLE to DONE directly.
  - stall_o=1 for cycle T only.
  - Writes HI <= srca_i and LO <= all-ones.
- Undefined: a zero divisor runs the full WIDTH iterations; the HI/LO result is unspecified.

Decomposition:
- Shared defines header holds:
  - the control codes: DIV_CONTROL, DIVU_CONTROL, MULT_CONTROL, MULTU_CONTROL, MTHI_CONTROL, MTLO_CONTROL;
  - the 2-bit FSM state encodings (IDLE/BUSY/DONE).
- One natural sub-module, div_radix2: the iterative unsigned core.
  - Inputs: start, abort, operands.
  - Outputs: quotient, remainder, done pulse.
- Signed handling, the multiplier and HI/LO stay in hilo_muldiv_unit.

Test Plan:
- DIV, srca=0xFFFFFFF9 (-7), srcb=2 -> stall_o high exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, srca=0xFFFFFFFF, srcb=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F after 33-cycle stall.
- MULT, 0xFFFFFFFF × 2 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. No stall in either case.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi_o=0x1234, lo_o=0x5678; with flush_i=1 on MTLO, LO stays unchanged.
- Prior HI=0xAA, LO=0xBB; DIV started, then flush_i at T+10 (and separately rst at T+10) -> HI=0xAA, LO=0xBB unchanged, stall_o=0 from T+10, busy_o=0 at T+11. After the rst case, HI=LO=0.
- DIVU, srcb=0 -> with DIV_ZERO_FAST_EN: 1-cycle stall, HI=srca_i, LO=0xFFFFFFFF. Without: 33-cycle stall; HI/LO not checked.
